cmp_acc_multi: RTL
==================

Name: cmp_acc_multi

Overview:
- Parametrised successor to the single-template bitmap compare accelerator.
- Holds one candidate symbol bitmap and NTEMPL stored templates, each ROWS x COLS bits.
- Streams one column per cycle through a popcount datapath and accumulates a per-template score. Mode selects match count or mismatch count.
- Reports the best-scoring template index and its score to the processor-side glue.

Parameters:
ROWS, 64, bits per column
COLS, 24, columns per bitmap; column c = bits [c*ROWS +: ROWS]
NTEMPL, 4, number of template slots (>=2)
SCORE_W, 16, score width; must satisfy 2^SCORE_W > ROWS*COLS
IDX_W, clog2(NTEMPL), template index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bmp_wr  in  1  load candidate bitmap
bmp_data  in  ROWS*COLS  candidate bitmap
tmpl_wr  in  1  write template slot
tmpl_idx  in  IDX_W  slot for tmpl_wr
tmpl_data  in  ROWS*COLS  template bitmap
mode  in  1  0 = score is matching bits (max wins); 1 = score is mismatching bits (min wins)
start  in  1  begin comparison
busy  out  1  high while scanning
done  out  1  one-cycle pulse when result valid
best_idx  out  IDX_W  winning template slot
best_score  out  SCORE_W  winning score
no_match  out  1  no valid template existed at start

Behaviour:
- Reset values: busy=0, done=0, best_idx=0, best_score=0, no_match=0. FSM=IDLE. Template valid bits cleared. Bitmap and template storage contents are not reset.
- Reset mid-scan: returns to IDLE next edge. No done pulse is produced. Partial results are discarded.
- bmp_wr, tmpl_wr: accepted only in IDLE, written on the clock edge.
  - tmpl_wr sets valid[tmpl_idx].
  - Writes while busy are ignored.
  - bmp_wr and tmpl_wr in the same cycle are both accepted.
- start: accepted only in IDLE; ignored while busy. Start in the same cycle as a bmp_wr/tmpl_wr uses the pre-write contents.
- mode and the valid mask are latched at start. Changing mode mid-scan has no effect.
- FSM:
  - IDLE -> SCAN on start.
  - SCAN -> DONE after the last column of slot NTEMPL-1.
  - DONE -> IDLE unconditionally.
- SCAN: counters tslot (0..NTEMPL-1) and col (0..COLS-1). Each cycle processes one column:
  - Column term = popcount(~(cand_col ^ tmpl_col)) in mode 0, or popcount(cand_col ^ tmpl_col) in mode 1. Term is zero-extended to SCORE_W.
  - Term is added to the accumulator; no overflow is possible given the SCORE_W constraint.
  - At col==COLS-1 the accumulated total is compared against the running best, then the accumulator is cleared, col wraps to 0 and tslot increments.
- All slots are scanned regardless of validity, so latency is fixed. Invalid slots never update the running best.
- Best update rule: strict > (mode 0) or strict < (mode 1), taking the first valid slot unconditionally. Ties keep the lower index.
- Latency: start sampled at edge T; busy=1 from T+1 through T+NTEMPL*COLS. done=1 for exactly the cycle after, T+NTEMPL*COLS+1 (defaults: T+97).
- Outputs best_idx, best_score, no_match update in the done cycle and hold until the next done or reset.
- No valid slots at start: done still pulses at the same latency with no_match=1, best_idx=0, best_score=0.
- busy=0 and done=1 in the DONE cycle. A new start is accepted the cycle after done.

Test Plan:
- Defaults. Write slots 0..3, slot 2 identical to the candidate. Others have 1, 10, 100 bits flipped. mode=0, start -> done at T+97, best_idx=2, best_score=1536, no_match=0.
- Same data, mode=1 -> best_idx=2, best_score=0. Then flip 5 bits in the candidate, rerun -> best_score=5, best_idx=2.
- Slots 1 and 3 identical, each 7 bits off the candidate; slot 0 never written, slot 2 at 50 bits off. mode=1 -> best_idx=1, best_score=7 (tie keeps lower index; invalid slot 0 skipped).
- After reset with no tmpl_wr, start -> done at T+97, no_match=1, best_idx=0, best_score=0.
- Start, then at T+40 assert rst for one cycle -> busy=0 next cycle, no done pulse. All outputs are 0, and valid bits are cleared: a subsequent start yields no_match=1.
- While busy, pulse start, bmp_wr and tmpl_wr with different data -> all ignored. Exactly one done at T+97, with result equal to the pre-start contents.

Source files
------------

// File: rtl/cmp_acc_multi.sv
// cmp_acc_multi: bitmap compare accelerator with NTEMPL template slots.
// Holds one candidate bitmap and NTEMPL templates (ROWS x COLS bits each).
// A scan streams one column per cycle through a popcount datapath, builds a
// per-template score (matching bits in mode 0, mismatching bits in mode 1),
// and reports the best-scoring valid slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bmp_wr, bmp_data         load candidate bitmap (IDLE only)
//   tmpl_wr, tmpl_idx,
//   tmpl_data                write a template slot and mark it valid (IDLE only)
//   mode                     0: max matching bits wins, 1: min mismatching bits wins
//   start                    begin a scan (IDLE only)
//   busy                     high while scanning
//   done                     one-cycle pulse when the result is valid
//   best_idx, best_score     winning slot and its score
//   no_match                 no slot was valid when the scan started
//
// States:
//   IDLE | accepts writes and start
//   SCAN | one column per cycle, slot by slot
//   DONE | result presented, done pulse
module cmp_acc_multi #(
  parameter int ROWS    = 64,
  parameter int COLS    = 24,
  parameter int NTEMPL  = 4,
  parameter int SCORE_W = 16,
  parameter int IDX_W   = $clog2(NTEMPL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bmp_wr,
  input  logic [ROWS*COLS-1:0]   bmp_data,
  input  logic                   tmpl_wr,
  input  logic [IDX_W-1:0]       tmpl_idx,
  input  logic [ROWS*COLS-1:0]   tmpl_data,
  input  logic                   mode,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       best_idx,
  output logic [SCORE_W-1:0]     best_score,
  output logic                   no_match
);

  localparam int BITS   = ROWS * COLS;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TERM_W = $clog2(ROWS + 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NTEMPL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [BITS-1:0]    cand;
  logic [BITS-1:0]    tmpl [NTEMPL];
  logic [NTEMPL-1:0]  valid;
  logic [NTEMPL-1:0]  valid_q;
  logic               mode_q;

  // Writes that arrive together with start are parked here and committed
  // in DONE, so the scan sees the pre-write contents.
  logic               pend_bmp_v;
  logic               pend_tmpl_v;
  logic [IDX_W-1:0]   pend_idx;
  logic [BITS-1:0]    pend_bmp;
  logic [BITS-1:0]    pend_tmpl;

  logic [COL_W-1:0]   col;
  logic [IDX_W-1:0]   tslot;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] run_best;
  logic [IDX_W-1:0]   run_idx;
  logic               run_found;

  logic [ROWS-1:0]    cand_col;
  logic [ROWS-1:0]    tmpl_col;
  logic [ROWS-1:0]    diff;
  logic [TERM_W-1:0]  term;
  logic [SCORE_W-1:0] total;
  logic               better;
  logic               take;
  logic               found_nxt;
  logic [SCORE_W-1:0] best_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               last_col;
  logic               last_slot;

  function automatic logic [TERM_W-1:0] popcount(input logic [ROWS-1:0] v);
    logic [TERM_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++) begin
      n = n + TERM_W'(v[i]);
    end
    return n;
  endfunction

  // Column datapath and running-best selection
  always_comb begin
    cand_col  = cand[col*ROWS +: ROWS];
    tmpl_col  = tmpl[tslot][col*ROWS +: ROWS];
    diff      = cand_col ^ tmpl_col;
    term      = popcount(mode_q ? diff : ~diff);
    total     = acc + SCORE_W'(term);
    better    = mode_q ? (total < run_best) : (total > run_best);
    // First valid slot is taken unconditionally; strict compare keeps the
    // lower index on ties.
    take      = valid_q[tslot] && (!run_found || better);
    found_nxt = run_found | take;
    best_nxt  = take ? total : run_best;
    idx_nxt   = take ? tslot : run_idx;
    last_col  = (col == LAST_COL);
    last_slot = (tslot == LAST_SLOT);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_col && last_slot) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  // Bitmap and template storage, not reset
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (bmp_wr) begin
        if (start) begin
          pend_bmp <= bmp_data;
        end else begin
          cand <= bmp_data;
        end
      end
      if (tmpl_wr) begin
        if (start) begin
          pend_tmpl <= tmpl_data;
          pend_idx  <= tmpl_idx;
        end else begin
          tmpl[tmpl_idx] <= tmpl_data;
        end
      end
    end else if (state == DONE) begin
      if (pend_bmp_v) cand <= pend_bmp;
      if (pend_tmpl_v) tmpl[pend_idx] <= pend_tmpl;
    end
  end

  // Scan control, accumulator, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      valid_q     <= '0;
      mode_q      <= 1'b0;
      pend_bmp_v  <= 1'b0;
      pend_tmpl_v <= 1'b0;
      col         <= '0;
      tslot       <= '0;
      acc         <= '0;
      run_best    <= '0;
      run_idx     <= '0;
      run_found   <= 1'b0;
      best_idx    <= '0;
      best_score  <= '0;
      no_match    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            valid_q     <= valid;
            col         <= '0;
            tslot       <= '0;
            acc         <= '0;
            run_best    <= '0;
            run_idx     <= '0;
            run_found   <= 1'b0;
            pend_bmp_v  <= bmp_wr;
            pend_tmpl_v <= tmpl_wr;
          end else if (tmpl_wr) begin
            valid[tmpl_idx] <= 1'b1;
          end
        end
        SCAN: begin
          if (last_col) begin
            acc       <= '0;
            col       <= '0;
            tslot     <= tslot + IDX_W'(1);
            run_best  <= best_nxt;
            run_idx   <= idx_nxt;
            run_found <= found_nxt;
            if (last_slot) begin
              best_idx   <= idx_nxt;
              best_score <= best_nxt;
              no_match   <= ~found_nxt;
            end
          end else begin
            acc <= total;
            col <= col + COL_W'(1);
          end
        end
        DONE: begin
          if (pend_tmpl_v) valid[pend_idx] <= 1'b1;
          pend_bmp_v  <= 1'b0;
          pend_tmpl_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
